// File: rtl/xgmii_link_fault_rs_if.sv
// XGMII bundle seen by the link-fault reconciliation sublayer.
// RX from the PHY, TX from the MAC, and the overridden TX toward the PHY.
interface xgmii_link_fault_rs_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] xgmii_txd_mac;
  logic [7:0]  xgmii_txc_mac;
  logic [63:0] xgmii_txd_phy;
  logic [7:0]  xgmii_txc_phy;

  modport slave (
    input  xgmii_rxd, xgmii_rxc, xgmii_txd_mac, xgmii_txc_mac,
    output xgmii_txd_phy, xgmii_txc_phy
  );

  modport master (
    output xgmii_rxd, xgmii_rxc, xgmii_txd_mac, xgmii_txc_mac,
    input  xgmii_txd_phy, xgmii_txc_phy
  );
endinterface

// File: rtl/xgmii_link_fault_rs.sv
// Reconciliation-sublayer link fault responder for a 64-bit XGMII.
// Tracks RX local/remote fault sequences, overrides MAC TX and counts fault entries.
module xgmii_link_fault_rs #(
  parameter int C_COL_WINDOW = 128,
  parameter int C_SEQ_THRESH = 4,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                   clk156,
  input  logic                   rst_n,
  xgmii_link_fault_rs_if.slave   xgmii,
  input  logic                   cnt_clear,
  output logic [1:0]             link_fault,
  output logic                   link_up,
  output logic [C_CNT_WIDTH-1:0] local_fault_cnt,
  output logic [C_CNT_WIDTH-1:0] remote_fault_cnt
);

  localparam int SEQ_W = $clog2(C_SEQ_THRESH + 1);
  localparam int COL_W = $clog2(C_COL_WINDOW + 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(C_SEQ_THRESH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(C_COL_WINDOW);

  localparam logic [63:0] TXD_RFAULT = 64'h0200009C_0200009C;
  localparam logic [7:0]  TXC_RFAULT = 8'h11;
  localparam logic [63:0] TXD_IDLE   = 64'h0707070707070707;
  localparam logic [7:0]  TXC_IDLE   = 8'hFF;

  // Encoding doubles as last-seen sequence type, with FLT_OK meaning "none".
  typedef enum logic [1:0] {
    FLT_OK     = 2'b00,
    FLT_LOCAL  = 2'b01,
    FLT_REMOTE = 2'b10
  } fault_e;

  fault_e                 link_fault_q, link_fault_d;
  fault_e                 last_seq_q, last_seq_d;
  logic [SEQ_W-1:0]       seq_cnt_q, seq_cnt_d;
  logic [COL_W-1:0]       col_cnt_q, col_cnt_d;
  logic [C_CNT_WIDTH-1:0] lcl_cnt_q, lcl_cnt_d;
  logic [C_CNT_WIDTH-1:0] rmt_cnt_q, rmt_cnt_d;
  logic [63:0]            txd_q, txd_d;
  logic [7:0]             txc_q, txc_d;

  function automatic fault_e col_seq_type(input logic [31:0] d, input logic [3:0] c);
    if (c == 4'b0001 && d[23:0] == 24'h00009C &&
        (d[31:24] == 8'h01 || d[31:24] == 8'h02))
      return fault_e'(d[25:24]);
    return FLT_OK;
  endfunction

  always_ff @(posedge clk156) begin
    if (!rst_n) begin
      link_fault_q <= FLT_OK;
      last_seq_q   <= FLT_OK;
      seq_cnt_q    <= '0;
      col_cnt_q    <= '0;
      lcl_cnt_q    <= '0;
      rmt_cnt_q    <= '0;
      txd_q        <= TXD_IDLE;
      txc_q        <= TXC_IDLE;
    end else begin
      link_fault_q <= link_fault_d;
      last_seq_q   <= last_seq_d;
      seq_cnt_q    <= seq_cnt_d;
      col_cnt_q    <= col_cnt_d;
      lcl_cnt_q    <= lcl_cnt_d;
      rmt_cnt_q    <= rmt_cnt_d;
      txd_q        <= txd_d;
      txc_q        <= txc_d;
    end
  end

  // Column 0 then column 1, chained so col1 sees col0's effect.
  always_comb begin
    fault_e t;
    t            = FLT_OK;
    last_seq_d   = last_seq_q;
    seq_cnt_d    = seq_cnt_q;
    col_cnt_d    = col_cnt_q;
    link_fault_d = link_fault_q;
    for (int i = 0; i < 2; i++) begin
      t = col_seq_type(xgmii.xgmii_rxd[32*i +: 32], xgmii.xgmii_rxc[4*i +: 4]);
      if (t != FLT_OK) begin
        if (t == last_seq_d) begin
          if (seq_cnt_d < SEQ_MAX) seq_cnt_d = seq_cnt_d + SEQ_W'(1);
        end else begin
          last_seq_d = t;
          seq_cnt_d  = SEQ_W'(1);
        end
        col_cnt_d = '0;
        if (seq_cnt_d == SEQ_MAX) link_fault_d = t;
      end else begin
        if (col_cnt_d < COL_MAX) col_cnt_d = col_cnt_d + COL_W'(1);
        if (col_cnt_d == COL_MAX) begin
          last_seq_d   = FLT_OK;
          seq_cnt_d    = '0;
          link_fault_d = FLT_OK;
        end
      end
    end
  end

  always_comb begin
    lcl_cnt_d = lcl_cnt_q;
    rmt_cnt_d = rmt_cnt_q;
    if (cnt_clear) begin
      lcl_cnt_d = '0;
      rmt_cnt_d = '0;
    end else begin
      if (link_fault_d == FLT_LOCAL && link_fault_q != FLT_LOCAL && lcl_cnt_q != '1)
        lcl_cnt_d = lcl_cnt_q + C_CNT_WIDTH'(1);
      if (link_fault_d == FLT_REMOTE && link_fault_q != FLT_REMOTE && rmt_cnt_q != '1)
        rmt_cnt_d = rmt_cnt_q + C_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    txd_d = xgmii.xgmii_txd_mac;
    txc_d = xgmii.xgmii_txc_mac;
    case (link_fault_q)
      FLT_LOCAL: begin
        txd_d = TXD_RFAULT;
        txc_d = TXC_RFAULT;
      end
      FLT_REMOTE: begin
        txd_d = TXD_IDLE;
        txc_d = TXC_IDLE;
      end
      default: ;
    endcase
  end

  assign link_fault          = link_fault_q;
  assign link_up             = (link_fault_q == FLT_OK);
  assign local_fault_cnt     = lcl_cnt_q;
  assign remote_fault_cnt    = rmt_cnt_q;
  assign xgmii.xgmii_txd_phy = txd_q;
  assign xgmii.xgmii_txc_phy = txc_q;

endmodule

// File: tb/tb_xgmii_link_fault_rs.sv
// Directed scoreboard bench for xgmii_link_fault_rs: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares one record per cycle.
module tb_xgmii_link_fault_rs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_clear;
  logic [1:0]  link_fault;
  logic        link_up;
  logic [15:0] local_fault_cnt;
  logic [15:0] remote_fault_cnt;

  xgmii_link_fault_rs_if xif();

  xgmii_link_fault_rs dut (
    .clk156          (clk),
    .rst_n           (rst_n),
    .xgmii           (xif),
    .cnt_clear       (cnt_clear),
    .link_fault      (link_fault),
    .link_up         (link_up),
    .local_fault_cnt (local_fault_cnt),
    .remote_fault_cnt(remote_fault_cnt)
  );

  always #3 clk = ~clk;

  localparam logic [31:0] LOC = 32'h0100009C;
  localparam logic [31:0] REM = 32'h0200009C;
  localparam logic [31:0] IDL = 32'h07070707;
  localparam logic [31:0] BAD = 32'h0300009C;

  typedef struct {
    int          id;
    logic [1:0]  lf;
    logic        up;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [15:0] lc;
    logic [15:0] rc;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pushes = 0;
  int          pops = 0;
  int          stepno = 0;
  logic [1:0]  prev_lf = 2'b00;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      pops++;
      chk("link_fault", e.id, 64'(link_fault), 64'(e.lf));
      chk("link_up", e.id, 64'(link_up), 64'(e.up));
      chk("txd_phy", e.id, xif.xgmii_txd_phy, e.txd);
      chk("txc_phy", e.id, 64'(xif.xgmii_txc_phy), 64'(e.txc));
      chk("local_cnt", e.id, 64'(local_fault_cnt), 64'(e.lc));
      chk("remote_cnt", e.id, 64'(remote_fault_cnt), 64'(e.rc));
    end
  end

  // Expected TX follows the link_fault expected one step earlier, or idle under reset.
  task automatic step(input logic rst, input logic clr, input logic [31:0] c1, input logic [31:0] c0,
                      input logic [7:0] rxc, input logic [1:0] e_lf, input int e_lc, input int e_rc);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n              = ~rst;
    cnt_clear          = clr;
    xif.xgmii_rxd      = {c1, c0};
    xif.xgmii_rxc      = rxc;
    xif.xgmii_txd_mac  = {~stepno[31:0], 32'hC0DE0000 + stepno[31:0]};
    xif.xgmii_txc_mac  = {4'h0, stepno[3:0]};
    e.id = stepno;
    e.lf = e_lf;
    e.up = (e_lf == 2'b00);
    e.lc = 16'(e_lc);
    e.rc = 16'(e_rc);
    if (rst || prev_lf == 2'b10) begin
      e.txd = 64'h0707070707070707;
      e.txc = 8'hFF;
    end else if (prev_lf == 2'b01) begin
      e.txd = 64'h0200009C_0200009C;
      e.txc = 8'h11;
    end else begin
      e.txd = xif.xgmii_txd_mac;
      e.txc = xif.xgmii_txc_mac;
    end
    q.push_back(e);
    pushes++;
    prev_lf = e_lf;
    stepno++;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clear = 1'b0;
    xif.xgmii_rxd = {IDL, IDL};
    xif.xgmii_rxc = 8'hFF;
    xif.xgmii_txd_mac = '0;
    xif.xgmii_txc_mac = '0;

    step(1, 0, IDL, IDL, 8'hFF, 2'b00, 0, 0);
    step(1, 0, IDL, IDL, 8'hFF, 2'b00, 0, 0);
    step(0, 0, IDL, IDL, 8'hFF, 2'b00, 0, 0);

    // Four local sequences in col0 -> LOCAL on the 4th, remote-fault TX one cycle later
    step(0, 0, IDL, LOC, 8'hF1, 2'b00, 0, 0);
    step(0, 0, IDL, LOC, 8'hF1, 2'b00, 0, 0);
    step(0, 0, IDL, LOC, 8'hF1, 2'b00, 0, 0);
    step(0, 0, IDL, LOC, 8'hF1, 2'b01, 1, 0);

    // col_cnt=1 after the 4th cycle: 63 idle cycles reach 127, the 64th reaches 128
    for (int i = 0; i < 63; i++) step(0, 0, IDL, IDL, 8'hFF, 2'b01, 1, 0);
    step(0, 0, IDL, IDL, 8'hFF, 2'b00, 1, 0);
    step(0, 0, IDL, IDL, 8'hFF, 2'b00, 1, 0);

    // 3 local, 1 remote, 3 local: type change restarts the run
    for (int i = 0; i < 3; i++) step(0, 0, IDL, LOC, 8'hF1, 2'b00, 1, 0);
    step(0, 0, IDL, REM, 8'hF1, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, IDL, LOC, 8'hF1, 2'b00, 1, 0);

    // Non-sequence columns: bad byte3, then correct data with wrong control
    for (int i = 0; i < 4; i++) step(0, 0, BAD, BAD, 8'h11, 2'b00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, LOC, LOC, 8'h00, 2'b00, 1, 0);

    step(1, 0, IDL, IDL, 8'hFF, 2'b00, 0, 0);

    // Local in both columns: 4 sequences over 2 cycles
    step(0, 0, LOC, LOC, 8'h11, 2'b00, 0, 0);
    step(0, 0, LOC, LOC, 8'h11, 2'b01, 1, 0);
    step(0, 0, IDL, IDL, 8'hFF, 2'b01, 1, 0);

    // Remote takes over, TX goes idle; then local again
    step(0, 0, REM, REM, 8'h11, 2'b01, 1, 0);
    step(0, 0, REM, REM, 8'h11, 2'b10, 1, 1);
    step(0, 0, IDL, IDL, 8'hFF, 2'b10, 1, 1);
    step(0, 0, IDL, IDL, 8'hFF, 2'b10, 1, 1);
    step(0, 0, LOC, LOC, 8'h11, 2'b10, 1, 1);
    step(0, 0, LOC, LOC, 8'h11, 2'b01, 2, 1);

    // LOCAL with remote seq_cnt=2, then reset discards the partial count
    step(0, 0, REM, REM, 8'h11, 2'b01, 2, 1);
    step(1, 0, IDL, IDL, 8'hFF, 2'b00, 0, 0);
    step(0, 0, REM, REM, 8'h11, 2'b00, 0, 0);
    step(0, 0, REM, REM, 8'h11, 2'b10, 0, 1);

    // cnt_clear wins over the LOCAL entry in the same cycle
    step(0, 0, LOC, LOC, 8'h11, 2'b10, 0, 1);
    step(0, 1, LOC, LOC, 8'h11, 2'b01, 0, 0);
    step(0, 0, IDL, IDL, 8'hFF, 2'b01, 0, 0);
    step(0, 0, IDL, IDL, 8'hFF, 2'b01, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    vectors++;
    if (pops != pushes) begin
      miscompares++;
      $display("FAIL drain: popped %0d expected %0d", pops, pushes);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
